eel_fetch_unit: RTL

//   Parametrised fetch stage for the EEL pipeline. It replaces the fixed PC/IMEM/fetch-register path with
//   a prefetching PC, a synchronous IMEM request path and a DEPTH-entry instruction queue.
//   It drives decode over a valid/ready handshake and accepts redirects from execute (jal/jalr/taken branch).

---
 rtl/eel_fetch_pkg.sv | 27 ++
 rtl/eel_fetch_queue.sv | 48 ++++
 rtl/eel_fetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/eel_fetch_pkg.sv
// eel_fetch_pkg: shared types and helpers for the EEL fetch stage.
//   fetch_entry_t  - one queue entry {pc, ir, pred}
//   NOP_INSTR      - value presented on D_IR when the queue is empty
//   OP_JAL/OP_BRANCH, j_imm/b_imm - used by the optional static predictor
// FETCH_XLEN fixes the entry PC width; the top's XLEN must match it.
package eel_fetch_pkg;
  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OP_JAL     = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH  = 7'b1100011;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           ir;
    logic                  pred;
  } fetch_entry_t;

  // J-type immediate, sign-extended
  function automatic logic [FETCH_XLEN-1:0] j_imm(input logic [31:0] ir);
    return {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

  // B-type immediate, sign-extended
  function automatic logic [FETCH_XLEN-1:0] b_imm(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/eel_fetch_queue.sv
// eel_fetch_queue: DEPTH-entry synchronous FIFO of fetch_entry_t.
//   CLK, RST (async active-low), FLUSH (clears, overrides PUSH/POP),
//   PUSH/DIN write, POP advances head (caller guarantees non-empty),
//   COUNT occupancy (log2(DEPTH)+1 bits), HEAD entry at the read pointer.
module eel_fetch_queue
  import eel_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         FLUSH,
  input  logic         PUSH,
  input  logic         POP,
  input  fetch_entry_t DIN,
  output logic [AW:0]  COUNT,
  output fetch_entry_t HEAD
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Storage needs no reset: HEAD is masked by the top while COUNT==0.
  always_ff @(posedge CLK)
    if (PUSH && !FLUSH) mem[wr_ptr] <= DIN;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= '0;
    end else begin
      if (PUSH) wr_ptr <= wr_ptr + 1'b1;
      if (POP)  rd_ptr <= rd_ptr + 1'b1;
      case ({PUSH, POP})
        2'b10:   COUNT <= COUNT + 1'b1;
        2'b01:   COUNT <= COUNT - 1'b1;
        default: ;
      endcase
    end
  end

  assign HEAD = mem[rd_ptr];
endmodule

// File: rtl/eel_fetch_unit.sv
// eel_fetch_unit: prefetching fetch stage for the EEL pipeline.
//   CLK/RST       clock, async active-low reset
//   IMEM_RDEN/ADDR word read request; IMEM_DATA returns the cycle after
//   REDIRECT/_PC  execute-stage flush and new PC (low 2 bits dropped)
//   D_VALID/READY decode handshake; D_PC, D_NEXTPC, D_IR, D_PRED from queue head
// Optional feature macro FETCH_BTFN_EN: static backward-taken/forward-not-taken
// prediction on the returning instruction (JAL always, branches with imm<0).
module eel_fetch_unit
  import eel_fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = FETCH_XLEN,
  parameter int unsigned      IMEM_AW  = 14,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               IMEM_RDEN,
  output logic [IMEM_AW-1:0] IMEM_ADDR,
  input  logic [31:0]        IMEM_DATA,
  input  logic               REDIRECT,
  input  logic [XLEN-1:0]    REDIRECT_PC,
  output logic               D_VALID,
  input  logic               D_READY,
  output logic [XLEN-1:0]    D_PC,
  output logic [XLEN-1:0]    D_NEXTPC,
  output logic [31:0]        D_IR,
  output logic               D_PRED
);
  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc, resp_pc;
  logic            inflight;
  logic [AW:0]     count;
  logic [AW+1:0]   space;
  logic            issue, fire, push, pop;
  fetch_entry_t    head, push_entry;

`ifdef FETCH_BTFN_EN
  logic [XLEN-1:0] fire_pc;
  always_comb begin
    fire    = 1'b0;
    fire_pc = resp_pc;
    if (inflight && IMEM_DATA[6:0] == OP_JAL) begin
      fire    = 1'b1;
      fire_pc = resp_pc + j_imm(IMEM_DATA);
    end else if (inflight && IMEM_DATA[6:0] == OP_BRANCH && IMEM_DATA[31]) begin
      fire    = 1'b1;
      fire_pc = resp_pc + b_imm(IMEM_DATA);
    end
  end
`else
  assign fire = 1'b0;
`endif

  // Reserve a slot for the in-flight response so a push never overflows.
  assign space     = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
  assign issue     = !REDIRECT && !fire && (space < (AW+2)'(DEPTH));
  assign IMEM_RDEN = issue && RST;
  assign IMEM_ADDR = fetch_pc[IMEM_AW+1:2];

  assign push       = inflight && !REDIRECT;
  assign pop        = D_VALID && D_READY && !REDIRECT;
  assign push_entry = '{pc: resp_pc, ir: IMEM_DATA, pred: fire};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= '0;
      inflight <= 1'b0;
    end else if (REDIRECT) begin
      fetch_pc <= REDIRECT_PC & ~XLEN'(3);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        resp_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + XLEN'(4);
      end
`ifdef FETCH_BTFN_EN
      else if (fire) fetch_pc <= fire_pc;
`endif
    end
  end

  eel_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .CLK   (CLK),
    .RST   (RST),
    .FLUSH (REDIRECT),
    .PUSH  (push),
    .POP   (pop),
    .DIN   (push_entry),
    .COUNT (count),
    .HEAD  (head)
  );

  assign D_VALID  = (count != '0);
  assign D_PC     = D_VALID ? head.pc : '0;
  assign D_IR     = D_VALID ? head.ir : NOP_INSTR;
  assign D_PRED   = D_VALID & head.pred;
  assign D_NEXTPC = D_PC + XLEN'(4);
endmodule
